// File: rtl/iir_sos_filter_pkg.sv
// iir_sos_filter_pkg: shared FSM states, coefficient slot indices and sizing helper for the biquad cascade.
package iir_sos_filter_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_UPD, ST_OUT} state_t;
    localparam int N_K = 5;
    localparam logic [2:0] K_B0 = 3'd0;
    localparam logic [2:0] K_B1 = 3'd1;
    localparam logic [2:0] K_B2 = 3'd2;
    localparam logic [2:0] K_A1 = 3'd3;
    localparam logic [2:0] K_A2 = 3'd4;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/iir_sos_filter_mac.sv
// iir_sos_filter_mac: signed multiply with registered add/subtract accumulate, plus round-half-up and saturation of the sum.
module iir_sos_filter_mac #(
    parameter int DATA_W     = 16,
    parameter int COEFF_W    = 16,
    parameter int COEFF_FRAC = 14,
    parameter int ACC_W      = 40
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      clr,
    input  logic                      acc_en,
    input  logic                      sub,
    input  logic signed [DATA_W-1:0]  a,
    input  logic signed [COEFF_W-1:0] c,
    output logic signed [DATA_W-1:0]  y
);
    localparam int PW = DATA_W + COEFF_W;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((longint'(1) << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(longint'(1) << (COEFF_FRAC - 1));
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc, pext, shr;
    logic                    hi, lo, sat;
    assign prod = a * c;
    assign pext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    assign shr  = (acc + HALF) >>> COEFF_FRAC;
    assign hi   = shr > MAXV;
    assign lo   = shr < MINV;
    assign sat  = hi | lo;
    assign y    = sat ? (hi ? MAXV[DATA_W-1:0] : MINV[DATA_W-1:0]) : shr[DATA_W-1:0];
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (acc_en)
            acc <= sub ? acc - pext : acc + pext;
    end
endmodule

// File: rtl/iir_sos_filter.sv
// iir_sos_filter: Direct Form I biquad cascade sharing one MAC, with valid/ready streaming and a run-time coefficient port.
module iir_sos_filter
    import iir_sos_filter_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int COEFF_W    = 16,
    parameter int COEFF_FRAC = 14,
    parameter int N_SECT     = 2,
    parameter int ACC_W      = 40
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_W-1:0]          in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DATA_W-1:0]          out_data,
    input  logic                              clear,
    input  logic                              coef_we,
    input  logic [$clog2(5*N_SECT)-1:0]       coef_addr,
    input  logic signed [COEFF_W-1:0]         coef_wdata,
    output logic                              coef_ready
);
    localparam int NC = N_K * N_SECT;
    localparam int AW = $clog2(NC);
    localparam int SW = idx_w(N_SECT);
    localparam logic signed [COEFF_W-1:0] B0_ONE = COEFF_W'(longint'(1) << COEFF_FRAC);
    state_t                     state, state_n;
    logic [2:0]                 k;
    logic [SW-1:0]              sect;
    logic signed [DATA_W-1:0]   x, y, mac_a;
    logic signed [COEFF_W-1:0]  coef [NC];
    logic signed [DATA_W-1:0]   x1 [N_SECT];
    logic signed [DATA_W-1:0]   x2 [N_SECT];
    logic signed [DATA_W-1:0]   y1 [N_SECT];
    logic signed [DATA_W-1:0]   y2 [N_SECT];
    logic [AW-1:0]              cidx;
    logic                       last;
    assign in_ready   = state == ST_IDLE;
    assign coef_ready = state == ST_IDLE;
    assign out_valid  = state == ST_OUT;
    assign last       = sect == SW'(N_SECT - 1);
    assign cidx       = AW'(N_K * int'(sect) + int'(k));
    always_comb begin
        mac_a = k == K_B0 ? x : k == K_B1 ? x1[sect] : k == K_B2 ? x2[sect] : k == K_A1 ? y1[sect] : y2[sect];
    end
    // Feedback taps (a1, a2) are subtracted so coefficients keep the tf2sos sign convention.
    iir_sos_filter_mac #(
        .DATA_W(DATA_W), .COEFF_W(COEFF_W), .COEFF_FRAC(COEFF_FRAC), .ACC_W(ACC_W)
    ) u_mac (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (state == ST_IDLE || state == ST_UPD || clear),
        .acc_en (state == ST_MAC),
        .sub    (k >= K_A1),
        .a      (mac_a),
        .c      (coef[cidx]),
        .y      (y)
    );
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (in_valid) state_n = ST_MAC;
            ST_MAC:  if (k == K_A2) state_n = ST_UPD;
            ST_UPD:  state_n = last ? ST_OUT : ST_MAC;
            ST_OUT:  if (out_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (clear && state != ST_IDLE) state_n = ST_IDLE;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NC; i++) coef[i] <= (i % N_K == 0) ? B0_ONE : '0;
            for (int i = 0; i < N_SECT; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
            x        <= '0;
            k        <= '0;
            sect     <= '0;
            out_data <= '0;
        end else begin
            if (coef_we && coef_ready && int'(coef_addr) < NC) coef[coef_addr] <= coef_wdata;
            if (clear) begin
                for (int i = 0; i < N_SECT; i++) begin
                    x1[i] <= '0;
                    x2[i] <= '0;
                    y1[i] <= '0;
                    y2[i] <= '0;
                end
            end
            if (state == ST_IDLE && in_valid) begin
                x    <= in_data;
                k    <= '0;
                sect <= '0;
            end
            if (state == ST_MAC && !clear) k <= k + 3'd1;
            // Section result becomes this section's y1 and the next section's input.
            if (state == ST_UPD && !clear) begin
                x2[sect] <= x1[sect];
                x1[sect] <= x;
                y2[sect] <= y1[sect];
                y1[sect] <= y;
                x        <= y;
                k        <= '0;
                if (last)
                    out_data <= y;
                else
                    sect <= sect + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_iir_sos_filter.sv
// tb_iir_sos_filter: randomized and directed stimulus checked every cycle against a sample-level model of the biquad cascade.
module tb_iir_sos_filter;
    localparam int N_SECT = 2;
    localparam int NC = 5 * N_SECT;
    localparam int LAT = 6 * N_SECT + 1;
    logic CLK, RST, in_valid, in_ready, out_valid, out_ready, clear, coef_we, coef_ready;
    logic signed [15:0] in_data, out_data, coef_wdata;
    logic [3:0] coef_addr;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    typedef struct {int t; longint y;} exp_t;
    exp_t q[$];
    longint got[$];
    longint mc[NC];
    longint mx1[N_SECT], mx2[N_SECT], my1[N_SECT], my2[N_SECT];
    logic idle, exp_v;

    iir_sos_filter #(.DATA_W(16), .COEFF_W(16), .COEFF_FRAC(14), .N_SECT(N_SECT), .ACC_W(40)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .clear(clear),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_ready(coef_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input longint a, input longint e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, a, e, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) mc[i] = (i % 5 == 0) ? 16384 : 0;
        model_zero();
    endfunction

    function automatic void model_zero();
        for (int s = 0; s < N_SECT; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endfunction

    // y = b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2, rounded half-up from Q14 and clamped to 16 bits.
    function automatic longint model_sample(input longint xin);
        longint xs = xin;
        longint acc, ys;
        for (int s = 0; s < N_SECT; s++) begin
            acc = mc[5*s]*xs + mc[5*s+1]*mx1[s] + mc[5*s+2]*mx2[s] - mc[5*s+3]*my1[s] - mc[5*s+4]*my2[s];
            ys = (acc + 8192) >>> 14;
            if (ys > 32767) ys = 32767;
            if (ys < -32768) ys = -32768;
            mx2[s] = mx1[s]; mx1[s] = xs; my2[s] = my1[s]; my1[s] = ys;
            xs = ys;
        end
        return xs;
    endfunction

    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            model_reset();
            q.delete();
        end
        idle = q.size() == 0;
        exp_v = q.size() > 0 && (cyc - q[0].t >= LAT);
        chk("in_ready", in_ready, idle);
        chk("coef_ready", coef_ready, idle);
        chk("out_valid", out_valid, exp_v);
        if (exp_v) chk("out_data", out_data, q[0].y);
        if (!RST) begin
            if (exp_v && out_ready) begin
                got.push_back(out_data);
                void'(q.pop_front());
            end
            if (clear) model_zero();
            if (clear && !idle) q.delete();
            if (coef_we && idle && int'(coef_addr) < NC) mc[coef_addr] = coef_wdata;
            if (in_valid && idle) q.push_back('{cyc, model_sample(in_data)});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic signed [15:0] v);
        int n = 0;
        in_valid = 1;
        in_data = v;
        do begin
            @(negedge CLK);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) chk("send_timeout", 0, 1);
        tick();
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_pending", q.size(), 0);
        tick();
    endtask

    task automatic wcoef(input logic [3:0] a, input logic signed [15:0] d);
        coef_we = 1; coef_addr = a; coef_wdata = d;
        tick();
        coef_we = 0;
    endtask

    task automatic pulse_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    task automatic chk_got(input string nm, input longint e0, input longint e1, input longint e2,
                           input longint e3, input longint e4, input int n);
        longint e[5];
        e = '{e0, e1, e2, e3, e4};
        chk({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) chk(nm, got[i], e[i]);
        got.delete();
    endtask

    initial begin
        int tmp;
        CLK = 0; RST = 1; in_valid = 0; in_data = 0; out_ready = 1; clear = 0;
        coef_we = 0; coef_addr = 0; coef_wdata = 0;
        repeat (2) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_coef_ready", coef_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        RST = 0;
        tick();
        send(1000); send(-32768); send(32767);
        drain();
        chk_got("passthru", 1000, -32768, 32767, 0, 0, 3);
        wcoef(0, 8192); wcoef(3, -8192);
        pulse_clear();
        repeat (5) send(16384);
        drain();
        chk_got("step", 8192, 12288, 14336, 15360, 15872, 5);
        wcoef(3, 0);
        pulse_clear();
        send(3); send(-3); send(1); send(-1);
        drain();
        chk_got("round", 2, -1, 1, 0, 0, 4);
        wcoef(0, 32767);
        send(32767); send(-32768);
        drain();
        chk_got("sat", 32767, -32768, 0, 0, 0, 2);
        for (int i = 0; i < 3000; i++) begin
            in_valid = $urandom_range(0, 1) == 1;
            in_data = 16'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            clear = $urandom_range(0, 49) == 0;
            coef_we = $urandom_range(0, 7) == 0;
            coef_addr = 4'($urandom_range(0, 15));
            tmp = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 16383)) - 8192;
            coef_wdata = 16'(tmp);
            tick();
        end
        in_valid = 0; clear = 0; coef_we = 0; out_ready = 1;
        drain();
        got.delete();
        send(111);
        out_ready = 0;
        in_valid = 1; in_data = 222;
        coef_we = 1; coef_addr = 0; coef_wdata = 0;
        repeat (3) tick();
        coef_we = 0;
        for (int i = 0; i < 32; i++) begin
            chk("stall_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1;
        send(222);
        drain();
        chk("stall_outputs", got.size(), 2);
        got.delete();
        send(500);
        repeat (3) tick();
        pulse_clear();
        send(700);
        repeat (4) tick();
        RST = 1;
        tick();
        RST = 0;
        repeat (20) tick();
        chk("abort_no_output", got.size(), 0);
        send(1234);
        drain();
        chk_got("after_reset", 1234, 0, 0, 0, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
